// File: rtl/tdm_frame_receiver.sv
// TDM frame receiver: demultiplexes a shared slot bus into NUM_LANES lanes.
// Slots are staged in a shadow buffer and committed to the lane registers
// atomically on the final slot, so lane_out never shows a partial frame.
module tdm_frame_receiver #(
  parameter int LANE_W    = 4,
  parameter int NUM_LANES = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [LANE_W-1:0]           bus_data,
  input  logic                        bus_valid,
  input  logic                        frame_start,
  output logic [NUM_LANES*LANE_W-1:0] lane_out,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int SLOT_W = $clog2(NUM_LANES);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  // The last slot is bypassed straight into the lane regs, so the shadow
  // only needs to hold slots 0..NUM_LANES-2.
  logic [NUM_LANES-2:0][LANE_W-1:0] shad_q, shad_d;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_q, lane_d;
  logic done_q, done_d;
  logic err_q, err_d;

  // Next-state logic for the receive FSM, shadow staging and lane commit
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idle_d  = idle_q;
    shad_d  = shad_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!enable) begin
      // Abort: drop any partial frame but keep the committed lanes.
      state_d = S_IDLE;
      slot_d  = '0;
      idle_d  = '0;
      shad_d  = '0;
      err_d   = (state_q == S_RECV);
    end else begin
      case (state_q)
        S_IDLE: begin
          idle_d = '0;
          if (bus_valid && frame_start) begin
            shad_d[0] = bus_data;
            slot_d    = SLOT_W'(1);
            state_d   = S_RECV;
          end
        end
        S_RECV: begin
          if (bus_valid) begin
            idle_d = '0;
            if (frame_start) begin
              // Resync: restart the frame from this beat.
              err_d     = 1'b1;
              shad_d[0] = bus_data;
              slot_d    = SLOT_W'(1);
            end else if (slot_q == LAST_SLOT) begin
              for (int k = 0; k < NUM_LANES - 1; k++) lane_d[k] = shad_q[k];
              lane_d[NUM_LANES-1] = bus_data;
              done_d  = 1'b1;
              slot_d  = '0;
              state_d = S_IDLE;
            end else begin
              for (int k = 0; k < NUM_LANES - 1; k++)
                if (slot_q == SLOT_W'(k)) shad_d[k] = bus_data;
              slot_d = slot_q + SLOT_W'(1);
            end
          end else if (idle_q == IDLE_LIM) begin
            // This idle cycle brings the count to TIMEOUT: give up on the frame.
            err_d   = 1'b1;
            shad_d  = '0;
            slot_d  = '0;
            idle_d  = '0;
            state_d = S_IDLE;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, staging and output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      idle_q  <= '0;
      shad_q  <= '0;
      lane_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idle_q  <= idle_d;
      shad_q  <= shad_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign lane_out   = enable ? lane_q : '0;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == S_RECV);

endmodule

// File: tb/tb_tdm_frame_receiver.sv
// Scoreboard bench for tdm_frame_receiver: expected commit/abort events are
// queued as stimulus is driven and popped when the DUT pulses an output.
module tb_tdm_frame_receiver;

  logic        clk, rst_n, enable, bus_valid, frame_start;
  logic [3:0]  bus_data;
  logic [15:0] lane_out;
  logic        frame_done, frame_err, busy;

  tdm_frame_receiver #(.LANE_W(4), .NUM_LANES(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus_data(bus_data),
    .bus_valid(bus_valid), .frame_start(frame_start), .lane_out(lane_out),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  typedef struct { bit is_err; logic [15:0] lanes; } exp_t;
  exp_t sb[$];
  int   done_t[$];
  int   nchk = 0, nerr = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frame_done || frame_err)) begin
      chk("done_err_excl", 32'(frame_done & frame_err), 0);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("evt_is_err", 32'(frame_err), 32'(e.is_err));
        if (frame_done && !e.is_err) chk("lane_at_done", 32'(lane_out), 32'(e.lanes));
      end
      if (frame_done) done_t.push_back(cyc);
    end
  end

  task automatic beat(input logic [3:0] d, input logic fs);
    bus_valid = 1'b1; bus_data = d; frame_start = fs;
    @(posedge clk); #1;
    bus_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [15:0] v);
    beat(v[3:0], 1'b1);
    beat(v[7:4], 1'b0);
    beat(v[11:8], 1'b0);
    sb.push_back('{1'b0, v});
    beat(v[15:12], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; enable = 1'b1; bus_valid = 1'b0; frame_start = 1'b0; bus_data = '0;
    idle(2);
    chk("rst_lane", 32'(lane_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    idle(1);

    // 1: basic frame
    frame(16'h4321);
    idle(1);
    chk("t1_lane", 32'(lane_out), 32'h4321);

    // 2: resync mid-frame
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    sb.push_back('{1'b1, 16'h0});
    beat(4'h5, 1'b1);
    chk("t2_busy", 32'(busy), 1);
    beat(4'h6, 1'b0);
    beat(4'h7, 1'b0);
    sb.push_back('{1'b0, 16'h8765});
    beat(4'h8, 1'b0);
    idle(2);
    chk("t2_lane", 32'(lane_out), 32'h8765);

    // 3: idle timeout
    beat(4'h9, 1'b1);
    beat(4'h9, 1'b0);
    idle(14);
    chk("t3_busy_before", 32'(busy), 1);
    sb.push_back('{1'b1, 16'h0});
    idle(2);
    chk("t3_busy_after", 32'(busy), 0);
    chk("t3_lane", 32'(lane_out), 32'h8765);

    // 4: back-to-back frames
    n0 = done_t.size();
    frame(16'h1111);
    frame(16'hF0F0);
    idle(2);
    chk("t4_ndone", 32'(done_t.size() - n0), 2);
    if (done_t.size() - n0 == 2) chk("t4_gap", 32'(done_t[n0+1] - done_t[n0]), 4);
    chk("t4_lane", 32'(lane_out), 32'hF0F0);

    // 5: enable dropped mid-frame
    beat(4'hC, 1'b1);
    beat(4'hD, 1'b0);
    enable = 1'b0;
    sb.push_back('{1'b1, 16'h0});
    beat(4'h7, 1'b1);
    idle(1);
    chk("t5_lane_off", 32'(lane_out), 0);
    chk("t5_busy", 32'(busy), 0);
    idle(2);
    enable = 1'b1;
    #1;
    chk("t5_lane_back", 32'(lane_out), 32'hF0F0);
    frame(16'h4321);
    idle(2);
    chk("t5_lane_new", 32'(lane_out), 32'h4321);

    // 6: stray beats while idle
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    idle(2);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_lane", 32'(lane_out), 32'h4321);

    // Reset asserted mid-frame
    beat(4'h5, 1'b1);
    beat(4'h6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lane", 32'(lane_out), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    frame(16'h1234);
    idle(2);
    chk("post_rst_lane", 32'(lane_out), 32'h1234);

    idle(3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
